pmp_cfg_regfile: RTL and testbench
==================================

# pmp_cfg_regfile

Holds the PMP and JITDomain (DMP) configuration state that the PMP checker consumes: per-entry `pmpcfg`, `pmpaddr` and `dmpcfg`.
- Serves the CSR file through a valid/ready request port, with lock and WARL legalization.
- Drives the packed configuration arrays read by every PMP checker instance.
- Provides a scrub sequence that clears all unlocked entries, for domain teardown.

## Interface
Parameters:
- `PMP_LEN`, 32 — pmpaddr width (rv64: 54).
- `NR_ENTRIES`, 4 — implemented entries, 0..16; entries at or above this index read as zero and are tied to zero on the outputs.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `req_valid_i`  in  1  CSR access request.
- `req_ready_o`  out  1  request can be accepted.
- `req_we_i`  in  1  1 = write, 0 = read.
- `req_sel_i`  in  2  target: 0 pmpcfg, 1 pmpaddr, 2 dmpcfg; 3 is illegal.
- `req_idx_i`  in  4  entry index.
- `req_wdata_i`  in  PMP_LEN  write data, LSB-aligned.
- `rsp_valid_o`  out  1  response strobe.
- `rsp_rdata_o`  out  PMP_LEN  read data, or the post-write stored value.
- `rsp_err_o`  out  1  access ignored: illegal select, illegal index, or locked.
- `scrub_i`  in  1  pulse; request a scrub of all unlocked entries.
- `busy_o`  out  1  scrub in progress.
- `cfg_changed_o`  out  1  one-cycle pulse when any output configuration changed.
- `conf_addr_o`  out  16×PMP_LEN  pmpaddr array.
- `pmpconf_o`  out  `riscv::pmpcfg_t[15:0]`.
- `dmpconf_o`  out  `riscv::dmpcfg_t[15:0]`.

## Operation
Reset values:
- all pmpcfg = 0 (mode OFF).
- all pmpaddr = 0.
- all dmpcfg: locked = 0, domain = `riscv::DOMI`.
- `req_ready_o` = 1; `rsp_valid_o`, `rsp_err_o`, `busy_o`, `cfg_changed_o` = 0; `rsp_rdata_o` = 0.

Write rules, per entry i:
- pmpcfg: ignored with err if `pmpconf[i].locked`.
  - WARL: W=1 with R=0 stores W=0.
  - Reserved bits always store 0.
- pmpaddr: ignored with err if `pmpconf[i].locked`, or if `pmpconf[i+1].locked` and `pmpconf[i+1].addr_mode == TOR` (for i+1 < NR_ENTRIES).
- dmpcfg: ignored with err if `dmpconf[i].locked`. The pmpcfg lock does not block dmpcfg.
- Lock bits are sticky; only reset clears them.

Other access rules:
- `req_idx_i >= NR_ENTRIES` or `req_sel_i == 3`: reads return 0, writes are dropped, err = 1.
- Reads never set err for a legal select/index. rdata is the zero-extended register.

FSM states:
- IDLE: ready = 1.
- SCRUB: ready = 0, busy = 1. Counter k runs 0..NR_ENTRIES-1, one entry per cycle.
  - Unlocked pmpcfg → 0.
  - pmpaddr → 0 under the same lock rule as a write.
  - Unlocked dmpcfg → domain DOMI.
- DONE: one cycle; `cfg_changed_o` = 1 if any entry changed during the scrub; → IDLE.

Transitions:
- IDLE → SCRUB on `scrub_i`, or on a pending scrub.
- If `scrub_i` arrives in the same cycle as an accepted request, the request completes first. The scrub is latched as pending and starts the next cycle.
- `scrub_i` while busy is ignored.
- NR_ENTRIES = 0: scrub goes IDLE → DONE directly, with no change pulse.

## Timing
- Request accepted on `req_valid_i & req_ready_o`.
- `rsp_valid_o` is high exactly one cycle later, with rdata and err valid in that cycle.
- Back-to-back requests are accepted every cycle.
- Write data appears on the `*_o` arrays in the cycle after acceptance.
- `cfg_changed_o` pulses in that same cycle only if the stored value actually differs.
- A read in the cycle after a write to the same register returns the new value.
- Scrub latency is NR_ENTRIES + 1 cycles from entering SCRUB to returning to IDLE. `busy_o` is high for NR_ENTRIES cycles.
- Reset asserted mid-scrub or mid-response: the next cycle is IDLE with all reset values, and no response is issued.

## Structure
- `pmpcfg_t`, `dmpcfg_t`, `pmp_addr_mode_t`, `dmp_domain_t` and `DOMI` stay in the `riscv` package.
- The select encodings (`PMPSEL_CFG`, `PMPSEL_ADDR`, `PMPSEL_DMP`) go into `riscv` as well, so the CSR file shares them.
- Sub-module `pmp_cfg_legalize`: combinational WARL/lock check for one write (old value, neighbour lock/mode, new value → stored value, err). Instantiated once for the request port and reused by the scrub path.

## Test plan
- Reset, then read pmpcfg[0] and dmpcfg[3] → rdata 0 and DOMI respectively, err 0; all outputs at reset values.
- Write pmpcfg[1] = 0x0A (TOR, W=1, R=0) → stored 0x08; rsp one cycle later; `cfg_changed_o` pulse.
- Set pmpcfg[2] = 0x8F (locked, TOR); then write pmpaddr[1] = 0x1234 → err 1, value unchanged; write pmpaddr[3] = 0x1234 → accepted.
- Write with idx 5 (NR_ENTRIES = 4) or sel 3 → err 1, read returns 0, no change pulse.
- Lock entry 0 only and write non-zero to all entries; pulse `scrub_i` → `busy_o` high for 4 cycles; entries 1–3 cleared with domain DOMI; entry 0 intact; one DONE pulse.
- `scrub_i` in the same cycle as an accepted write → write response first, scrub starts the next cycle; assert `rst_ni` = 0 mid-scrub → all reset values and IDLE the following cycle.

Source files
------------

// File: rtl/pmp_cfg_regfile_pkg.sv
// Shared PMP/JITDomain configuration types and the regfile's local helpers.
package riscv;
  typedef enum logic [1:0] {
    OFF   = 2'b00,
    TOR   = 2'b01,
    NA4   = 2'b10,
    NAPOT = 2'b11
  } pmp_addr_mode_t;

  typedef struct packed {
    logic x;
    logic w;
    logic r;
  } pmpcfg_access_t;

  typedef struct packed {
    logic           locked;
    logic [1:0]     reserved;
    pmp_addr_mode_t addr_mode;
    pmpcfg_access_t access_type;
  } pmpcfg_t;

  typedef enum logic [2:0] {
    DOM0 = 3'd0,
    DOMI = 3'd1,
    DOM2 = 3'd2,
    DOM3 = 3'd3,
    DOM4 = 3'd4,
    DOM5 = 3'd5,
    DOM6 = 3'd6,
    DOM7 = 3'd7
  } dmp_domain_t;

  typedef struct packed {
    logic        locked;
    logic [3:0]  reserved;
    dmp_domain_t domain;
  } dmpcfg_t;

  // CSR-side target select encodings, shared with the CSR file.
  localparam logic [1:0] PMPSEL_CFG  = 2'd0;
  localparam logic [1:0] PMPSEL_ADDR = 2'd1;
  localparam logic [1:0] PMPSEL_DMP  = 2'd2;
endpackage

package pmp_cfg_regfile_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCRUB = 2'd1,
    ST_DONE  = 2'd2
  } scrub_state_e;

  localparam riscv::dmpcfg_t DMPCFG_RESET = '{locked: 1'b0, reserved: 4'd0, domain: riscv::DOMI};

  // Reserved bits forced to zero; W without R is not a legal combination.
  function automatic riscv::pmpcfg_t legalize_pmpcfg(input logic [7:0] v);
    riscv::pmpcfg_t c;
    c = riscv::pmpcfg_t'(v);
    c.reserved = 2'b00;
    if (c.access_type.w && !c.access_type.r) c.access_type.w = 1'b0;
    return c;
  endfunction

  // Only the lock bit and the domain field are stored.
  function automatic riscv::dmpcfg_t legalize_dmpcfg(input logic [7:0] v);
    riscv::dmpcfg_t c;
    c = riscv::dmpcfg_t'(v);
    c.reserved = 4'd0;
    return c;
  endfunction
endpackage

// File: rtl/pmp_cfg_regfile_legalize.sv
// Combinational lock and WARL check for one entry: lock flags, old value and stored value.
module pmp_cfg_legalize
  import pmp_cfg_regfile_pkg::*;
#(
  parameter int PMP_LEN = 32
) (
  input  logic [1:0]         sel_i,
  input  riscv::pmpcfg_t     cur_cfg_i,
  input  logic [PMP_LEN-1:0] cur_addr_i,
  input  riscv::dmpcfg_t     cur_dmp_i,
  input  logic               nxt_tor_locked_i,
  input  logic [PMP_LEN-1:0] wdata_i,
  output logic               cfg_locked_o,
  output logic               addr_locked_o,
  output logic               dmp_locked_o,
  output logic [PMP_LEN-1:0] old_o,
  output logic [PMP_LEN-1:0] new_o,
  output logic               err_o
);
  logic [PMP_LEN-1:0] legal;

  // A locked TOR neighbour also freezes this entry's address, since it is that region's base.
  always_comb begin
    cfg_locked_o  = cur_cfg_i.locked;
    addr_locked_o = cur_cfg_i.locked | nxt_tor_locked_i;
    dmp_locked_o  = cur_dmp_i.locked;
    old_o         = '0;
    legal         = '0;
    err_o         = 1'b1;
    unique case (sel_i)
      riscv::PMPSEL_CFG: begin
        old_o = PMP_LEN'(cur_cfg_i);
        legal = PMP_LEN'(legalize_pmpcfg(wdata_i[7:0]));
        err_o = cfg_locked_o;
      end
      riscv::PMPSEL_ADDR: begin
        old_o = cur_addr_i;
        legal = wdata_i;
        err_o = addr_locked_o;
      end
      riscv::PMPSEL_DMP: begin
        old_o = PMP_LEN'(cur_dmp_i);
        legal = PMP_LEN'(legalize_dmpcfg(wdata_i[7:0]));
        err_o = dmp_locked_o;
      end
      default: begin
        old_o = '0;
        legal = '0;
        err_o = 1'b1;
      end
    endcase
    new_o = err_o ? old_o : legal;
  end
endmodule

// File: rtl/pmp_cfg_regfile.sv
// PMP / JITDomain configuration register file with CSR request port and scrub sequence.
module pmp_cfg_regfile
  import pmp_cfg_regfile_pkg::*;
#(
  parameter int PMP_LEN    = 32,
  parameter int NR_ENTRIES = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic                          req_we_i,
  input  logic [1:0]                    req_sel_i,
  input  logic [3:0]                    req_idx_i,
  input  logic [PMP_LEN-1:0]            req_wdata_i,
  output logic                          rsp_valid_o,
  output logic [PMP_LEN-1:0]            rsp_rdata_o,
  output logic                          rsp_err_o,
  input  logic                          scrub_i,
  output logic                          busy_o,
  output logic                          cfg_changed_o,
  output logic [15:0][PMP_LEN-1:0]      conf_addr_o,
  output riscv::pmpcfg_t [15:0]         pmpconf_o,
  output riscv::dmpcfg_t [15:0]         dmpconf_o
);
  scrub_state_e state_q, state_d;
  logic [3:0] k_q, k_d;
  logic pending_q, pending_d;
  logic scrub_chg_q, scrub_chg_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_err_q, rsp_err_d;
  logic [PMP_LEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic cfg_changed_q, cfg_changed_d;
  riscv::pmpcfg_t [15:0] cfg_q, cfg_d;
  logic [15:0][PMP_LEN-1:0] addr_q, addr_d;
  riscv::dmpcfg_t [15:0] dmp_q, dmp_d;

  logic req_fire, in_scrub, idx_ok, nxt_ok, nxt_tor_locked, scrub_hit;
  logic [3:0] idx, nxt_idx;
  logic leg_cfg_locked, leg_addr_locked, leg_dmp_locked, leg_err;
  logic [PMP_LEN-1:0] leg_old, leg_new;

  assign req_ready_o   = (state_q == ST_IDLE) && !pending_q;
  assign req_fire      = req_valid_i && req_ready_o;
  assign in_scrub      = (state_q == ST_SCRUB);
  assign idx           = in_scrub ? k_q : req_idx_i;
  assign nxt_idx       = idx + 4'd1;
  assign idx_ok        = int'(idx) < NR_ENTRIES;
  assign nxt_ok        = int'(idx) + 1 < NR_ENTRIES;
  assign nxt_tor_locked = nxt_ok && cfg_q[nxt_idx].locked && (cfg_q[nxt_idx].addr_mode == riscv::TOR);

  // The scrub path shares this instance: during SCRUB the index is the scrub counter.
  pmp_cfg_legalize #(.PMP_LEN(PMP_LEN)) u_legalize (
    .sel_i            (req_sel_i),
    .cur_cfg_i        (cfg_q[idx]),
    .cur_addr_i       (addr_q[idx]),
    .cur_dmp_i        (dmp_q[idx]),
    .nxt_tor_locked_i (nxt_tor_locked),
    .wdata_i          (req_wdata_i),
    .cfg_locked_o     (leg_cfg_locked),
    .addr_locked_o    (leg_addr_locked),
    .dmp_locked_o     (leg_dmp_locked),
    .old_o            (leg_old),
    .new_o            (leg_new),
    .err_o            (leg_err)
  );

  // Next-state: request handling in IDLE, one entry per cycle in SCRUB, change pulse in DONE.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    pending_d     = pending_q;
    scrub_chg_d   = scrub_chg_q;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    cfg_changed_d = 1'b0;
    cfg_d         = cfg_q;
    addr_d        = addr_q;
    dmp_d         = dmp_q;
    scrub_hit     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          rsp_valid_d = 1'b1;
          if (!idx_ok || req_sel_i == 2'd3) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (req_we_i) begin
            rsp_err_d   = leg_err;
            rsp_rdata_d = leg_new;
            if (!leg_err) begin
              cfg_changed_d = (leg_new != leg_old);
              unique case (req_sel_i)
                riscv::PMPSEL_CFG:  cfg_d[idx]  = riscv::pmpcfg_t'(leg_new[7:0]);
                riscv::PMPSEL_ADDR: addr_d[idx] = leg_new;
                default:            dmp_d[idx]  = riscv::dmpcfg_t'(leg_new[7:0]);
              endcase
            end
          end else begin
            rsp_rdata_d = leg_old;
          end
          if (scrub_i) pending_d = 1'b1;
        end else if (scrub_i || pending_q) begin
          pending_d   = 1'b0;
          scrub_chg_d = 1'b0;
          k_d         = 4'd0;
          state_d     = (NR_ENTRIES == 0) ? ST_DONE : ST_SCRUB;
        end
      end
      ST_SCRUB: begin
        if (!leg_cfg_locked && cfg_q[k_q] != riscv::pmpcfg_t'(8'h00)) begin
          cfg_d[k_q] = riscv::pmpcfg_t'(8'h00);
          scrub_hit  = 1'b1;
        end
        if (!leg_addr_locked && addr_q[k_q] != '0) begin
          addr_d[k_q] = '0;
          scrub_hit   = 1'b1;
        end
        if (!leg_dmp_locked && dmp_q[k_q] != DMPCFG_RESET) begin
          dmp_d[k_q] = DMPCFG_RESET;
          scrub_hit  = 1'b1;
        end
        if (int'(k_q) == NR_ENTRIES - 1) begin
          state_d       = ST_DONE;
          cfg_changed_d = scrub_chg_q | scrub_hit;
        end else begin
          k_d         = k_q + 4'd1;
          scrub_chg_d = scrub_chg_q | scrub_hit;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registers; reset restores every configuration entry and idles the port.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      k_q           <= 4'd0;
      pending_q     <= 1'b0;
      scrub_chg_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      cfg_changed_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        cfg_q[i]  <= riscv::pmpcfg_t'(8'h00);
        addr_q[i] <= '0;
        dmp_q[i]  <= (i < NR_ENTRIES) ? DMPCFG_RESET : riscv::dmpcfg_t'(8'h00);
      end
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      pending_q     <= pending_d;
      scrub_chg_q   <= scrub_chg_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_rdata_q   <= rsp_rdata_d;
      cfg_changed_q <= cfg_changed_d;
      cfg_q         <= cfg_d;
      addr_q        <= addr_d;
      dmp_q         <= dmp_d;
    end
  end

  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign cfg_changed_o = cfg_changed_q;
  assign busy_o        = in_scrub;

  // Unimplemented entries are tied to zero on the checker-facing arrays.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      pmpconf_o[i]   = (i < NR_ENTRIES) ? cfg_q[i]  : riscv::pmpcfg_t'(8'h00);
      conf_addr_o[i] = (i < NR_ENTRIES) ? addr_q[i] : '0;
      dmpconf_o[i]   = (i < NR_ENTRIES) ? dmp_q[i]  : riscv::dmpcfg_t'(8'h00);
    end
  end
endmodule

// File: tb/tb_pmp_cfg_regfile.sv
// Bench for pmp_cfg_regfile: directed checks plus randomized traffic against a behavioural model.
module tb_pmp_cfg_regfile;
  localparam int NR = 4;
  localparam int PL = 32;
  localparam logic [7:0] DMP_RST = {5'b00000, riscv::DOMI};

  logic clk = 1'b0;
  logic rst_n, req_valid, req_ready, req_we, rsp_valid, rsp_err, scrub, busy, cfg_changed;
  logic [1:0] req_sel;
  logic [3:0] req_idx;
  logic [PL-1:0] req_wdata, rsp_rdata;
  logic [15:0][PL-1:0] conf_addr;
  riscv::pmpcfg_t [15:0] pmpconf;
  riscv::dmpcfg_t [15:0] dmpconf;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pmp_cfg_regfile #(.PMP_LEN(PL), .NR_ENTRIES(NR)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_sel_i(req_sel), .req_idx_i(req_idx), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .scrub_i(scrub), .busy_o(busy), .cfg_changed_o(cfg_changed),
    .conf_addr_o(conf_addr), .pmpconf_o(pmpconf), .dmpconf_o(dmpconf)
  );

  // ---------------- behavioural model ----------------
  logic [7:0]  m_cfg [16];
  logic [31:0] m_addr[16];
  logic [7:0]  m_dmp [16];
  int m_busy_left;
  bit m_done, m_pending, m_scrub_chg, m_rsp_valid, m_rsp_err, m_changed, m_started;
  logic [31:0] m_rdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] leg_cfg(input logic [31:0] w);
    logic [7:0] v;
    v = w[7:0] & 8'h9F;
    if (v[1] && !v[0]) v[1] = 1'b0;
    return v;
  endfunction

  function automatic logic [7:0] leg_dmp(input logic [31:0] w);
    return w[7:0] & 8'h87;
  endfunction

  function automatic bit addr_locked(input int i);
    if (m_cfg[i][7]) return 1'b1;
    if (i + 1 < NR) return m_cfg[i+1][7] && (m_cfg[i+1][4:3] == 2'b01);
    return 1'b0;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_cfg[i] = 8'h00;
      m_addr[i] = 32'h0;
      m_dmp[i] = (i < NR) ? DMP_RST : 8'h00;
    end
    m_busy_left = 0; m_done = 0; m_pending = 0; m_scrub_chg = 0;
    m_rsp_valid = 0; m_rsp_err = 0; m_changed = 0; m_rdata = 32'h0;
  endtask

  task automatic m_request();
    int i;
    logic [31:0] cur, nw;
    bit lk;
    i = int'(req_idx);
    m_rsp_valid = 1;
    if (i >= NR || req_sel == 2'd3) begin
      m_rsp_err = 1; m_rdata = 32'h0;
      return;
    end
    case (req_sel)
      2'd0: begin cur = 32'(m_cfg[i]); lk = m_cfg[i][7]; nw = 32'(leg_cfg(req_wdata)); end
      2'd1: begin cur = m_addr[i]; lk = addr_locked(i); nw = req_wdata; end
      default: begin cur = 32'(m_dmp[i]); lk = m_dmp[i][7]; nw = 32'(leg_dmp(req_wdata)); end
    endcase
    if (!req_we) begin
      m_rsp_err = 0; m_rdata = cur;
    end else if (lk) begin
      m_rsp_err = 1; m_rdata = cur;
    end else begin
      m_rsp_err = 0; m_rdata = nw; m_changed = (nw != cur);
      case (req_sel)
        2'd0: m_cfg[i] = nw[7:0];
        2'd1: m_addr[i] = nw;
        default: m_dmp[i] = nw[7:0];
      endcase
    end
  endtask

  task automatic m_step();
    int k;
    bit lc, la, ld, hit;
    if (!rst_n) begin m_reset(); m_started = 1; return; end
    m_rsp_valid = 0; m_changed = 0;
    if (m_busy_left > 0) begin
      k = NR - m_busy_left;
      lc = m_cfg[k][7]; la = addr_locked(k); ld = m_dmp[k][7]; hit = 0;
      if (!lc && m_cfg[k] != 8'h00) begin m_cfg[k] = 8'h00; hit = 1; end
      if (!la && m_addr[k] != 32'h0) begin m_addr[k] = 32'h0; hit = 1; end
      if (!ld && m_dmp[k] != DMP_RST) begin m_dmp[k] = DMP_RST; hit = 1; end
      m_scrub_chg = m_scrub_chg | hit;
      m_busy_left--;
      if (m_busy_left == 0) begin m_done = 1; m_changed = m_scrub_chg; end
    end else if (m_done) begin
      m_done = 0;
    end else if (req_valid && !m_pending) begin
      m_request();
      if (scrub) m_pending = 1;
    end else if (scrub || m_pending) begin
      m_pending = 0; m_scrub_chg = 0;
      if (NR == 0) m_done = 1;
      else m_busy_left = NR;
    end
    m_started = 1;
  endtask

  initial begin
    m_started = 0;
    m_reset();
    forever begin
      @(posedge clk);
      m_step();
    end
  end

  // Compare every output against the model on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        chk("ready", 64'(req_ready), 64'(m_busy_left == 0 && !m_done && !m_pending));
        chk("busy", 64'(busy), 64'(m_busy_left > 0));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
        chk("cfg_changed", 64'(cfg_changed), 64'(m_changed));
        if (m_rsp_valid) begin
          chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
          chk("rsp_err", 64'(rsp_err), 64'(m_rsp_err));
        end
        for (int i = 0; i < 16; i++) begin
          chk($sformatf("pmpcfg[%0d]", i), 64'(pmpconf[i]), 64'(m_cfg[i]));
          chk($sformatf("pmpaddr[%0d]", i), 64'(conf_addr[i]), 64'(m_addr[i]));
          chk($sformatf("dmpcfg[%0d]", i), 64'(dmpconf[i]), 64'(m_dmp[i]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic req(input logic we, input logic [1:0] sel, input logic [3:0] idx,
                     input logic [31:0] wd, input logic scr);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_wait", 64'(n < 50), 64'(1));
    req_valid = 1'b1; req_we = we; req_sel = sel; req_idx = idx; req_wdata = wd; scrub = scr;
    @(negedge clk);
    req_valid = 1'b0; scrub = 1'b0;
  endtask

  int nb, nc;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_sel = 2'd0; req_idx = 4'd0;
    req_wdata = 32'h0; scrub = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(1));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_dmp0", 64'(dmpconf[0]), 64'(8'h01));
    rst_n = 1'b1;

    req(1'b0, 2'd0, 4'd0, 32'h0, 1'b0);
    chk("rd_cfg0_valid", 64'(rsp_valid), 64'(1));
    chk("rd_cfg0_data", 64'(rsp_rdata), 64'(0));
    chk("rd_cfg0_err", 64'(rsp_err), 64'(0));
    req(1'b0, 2'd2, 4'd3, 32'h0, 1'b0);
    chk("rd_dmp3_data", 64'(rsp_rdata), 64'(1));
    req(1'b1, 2'd0, 4'd1, 32'h0A, 1'b0);
    chk("wr_cfg1_data", 64'(rsp_rdata), 64'(8'h08));
    chk("wr_cfg1_chg", 64'(cfg_changed), 64'(1));
    chk("wr_cfg1_out", 64'(pmpconf[1]), 64'(8'h08));
    req(1'b1, 2'd0, 4'd2, 32'h8F, 1'b0);
    chk("wr_cfg2_data", 64'(rsp_rdata), 64'(8'h8F));
    req(1'b1, 2'd1, 4'd1, 32'h1234, 1'b0);
    chk("wr_addr1_err", 64'(rsp_err), 64'(1));
    chk("wr_addr1_out", 64'(conf_addr[1]), 64'(0));
    req(1'b1, 2'd1, 4'd3, 32'h1234, 1'b0);
    chk("wr_addr3_err", 64'(rsp_err), 64'(0));
    chk("wr_addr3_out", 64'(conf_addr[3]), 64'(32'h1234));
    req(1'b1, 2'd0, 4'd5, 32'h07, 1'b0);
    chk("wr_idx5_err", 64'(rsp_err), 64'(1));
    chk("wr_idx5_chg", 64'(cfg_changed), 64'(0));
    req(1'b0, 2'd0, 4'd5, 32'h0, 1'b0);
    chk("rd_idx5_data", 64'(rsp_rdata), 64'(0));
    req(1'b1, 2'd3, 4'd0, 32'h55, 1'b0);
    chk("wr_sel3_err", 64'(rsp_err), 64'(1));

    // scrub with entry 0 locked
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) req(1'b1, 2'd1, 4'(i), 32'h100 + 32'(i), 1'b0);
    for (int i = 1; i < 4; i++) req(1'b1, 2'd0, 4'(i), 32'h1F, 1'b0);
    for (int i = 1; i < 4; i++) req(1'b1, 2'd2, 4'(i), 32'h02, 1'b0);
    req(1'b1, 2'd2, 4'd0, 32'h83, 1'b0);
    req(1'b1, 2'd0, 4'd0, 32'h89, 1'b0);
    @(negedge clk); scrub = 1'b1;
    nb = 0; nc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); scrub = 1'b0;
      nb += int'(busy); nc += int'(cfg_changed);
    end
    chk("scrub_busy_cycles", 64'(nb), 64'(4));
    chk("scrub_done_pulses", 64'(nc), 64'(1));
    chk("scrub_cfg0_kept", 64'(pmpconf[0]), 64'(8'h89));
    chk("scrub_addr0_kept", 64'(conf_addr[0]), 64'(32'h100));
    chk("scrub_dmp0_kept", 64'(dmpconf[0]), 64'(8'h83));
    chk("scrub_cfg2_clr", 64'(pmpconf[2]), 64'(0));
    chk("scrub_addr3_clr", 64'(conf_addr[3]), 64'(0));
    chk("scrub_dmp1_domi", 64'(dmpconf[1]), 64'(8'h01));

    // scrub together with an accepted write, then reset mid-scrub
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_sel = 2'd0; req_idx = 4'd1; req_wdata = 32'h05; scrub = 1'b1;
    @(negedge clk); req_valid = 1'b0; scrub = 1'b0;
    chk("co_rsp_first", 64'(rsp_valid), 64'(1));
    chk("co_rsp_data", 64'(rsp_rdata), 64'(8'h05));
    chk("co_not_busy_yet", 64'(busy), 64'(0));
    @(negedge clk);
    chk("co_busy_next", 64'(busy), 64'(1));
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_ready", 64'(req_ready), 64'(1));
    chk("midrst_cfg0", 64'(pmpconf[0]), 64'(0));

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      rst_n     = ($urandom_range(0, 299) != 0);
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_sel   = 2'($urandom_range(0, 3));
      req_idx   = 4'($urandom_range(0, 5));
      req_wdata = $urandom;
      if (req_sel != 2'd1) req_wdata[7] = ($urandom_range(0, 7) == 0);
      scrub     = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0; scrub = 1'b0;
    repeat (12) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
